dff_scan_sequencer: RTL and testbench

Autonomous sequencer for the DUT DFF-chain PISO readout. It generates the load, shift_clk and save_data sequence that captures and shifts out every DB_DFFQ chain, one scan or back-to-back scans with a fixed gap, and counts completed scans. It also arbitrates the PISO controls between the FPGA sequencer and the RPi manual-control pins. It sits between the RPi interface and the load0/1, shift_clk0/1 and DFF_DATA_OUTPUT save inputs in the DFF test top.

---
 rtl/dff_scan_sequencer_if.sv | 41 ++++
 rtl/dff_scan_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_dff_scan_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_scan_sequencer_if.sv
// dff_scan_sequencer_if
// Groups the RPi-side control, manual-override and PISO-side signals of the
// DFF-chain scan sequencer into one bundle.
// master : the controlling side (RPi / test environment).
// slave  : the sequencer itself.

interface dff_scan_sequencer_if #(
    parameter int CNT_W = 16
);
    // Control requests from the RPi side
    logic             start;
    logic             cont;
    logic             abort;
    logic             clear_cnt;

    // Manual override request and the RPi manual PISO controls
    logic             man_sel;
    logic             shift_clk_pi;
    logic             load_pi;
    logic             save_pi;

    // PISO-side outputs and status
    logic             shift_clk;
    logic             load;
    logic             save_data;
    logic             busy;
    logic             scan_done;
    logic [CNT_W-1:0] scan_count;

    modport master (
        output start, cont, abort, clear_cnt,
        output man_sel, shift_clk_pi, load_pi, save_pi,
        input  shift_clk, load, save_data, busy, scan_done, scan_count
    );

    modport slave (
        input  start, cont, abort, clear_cnt,
        input  man_sel, shift_clk_pi, load_pi, save_pi,
        output shift_clk, load, save_data, busy, scan_done, scan_count
    );
endinterface

// File: rtl/dff_scan_sequencer.sv
// dff_scan_sequencer
// Autonomous load / shift_clk / save_data sequencer for the DFF-chain PISO
// readout. A scan is one load pulse, CHAIN_LEN shift_clk pulses, then a
// single-cycle save pulse. Continuous mode repeats scans with a GAP-cycle
// pause between them. All sequencer-generated controls come straight from
// flops so the PISO clock is glitch-free; only the manual-override path
// is combinational, because the RPi must drive the chains directly.

module dff_scan_sequencer #(
    parameter int CHAIN_LEN = 64,
    parameter int HALF_PER  = 4,
    parameter int GAP       = 1000,
    parameter int CNT_W     = 16
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    dff_scan_sequencer_if.slave   bus
);

    // One timer serves both the half-period and the inter-scan gap.
    localparam int TMR_MAX = (HALF_PER > GAP) ? HALF_PER : GAP;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int PLS_W   = $clog2(CHAIN_LEN) + 1;

    localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_PER - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP - 1);
    localparam logic [PLS_W-1:0] PULSE_LAST = PLS_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_SAVE     = 3'd4,
        S_WAIT     = 3'd5
    } state_t;

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [PLS_W-1:0] pulse_q;
    logic             load_q;
    logic             shift_q;
    logic             save_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] scan_count_q;
    logic [CNT_W-1:0] scan_count_d;
    logic             kill_s;

    // Manual takeover behaves exactly like an abort for the sequencer.
    assign kill_s = bus.abort | bus.man_sel;

    // Scan FSM: state, timers and the registered PISO controls.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= S_IDLE;
            tmr_q   <= {TMR_W{1'b0}};
            pulse_q <= {PLS_W{1'b0}};
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            save_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (kill_s) begin
            state_q <= S_IDLE;
            tmr_q   <= {TMR_W{1'b0}};
            pulse_q <= {PLS_W{1'b0}};
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            save_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start || bus.cont) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    tmr_q   <= {TMR_W{1'b0}};
                    pulse_q <= {PLS_W{1'b0}};
                    shift_q <= 1'b0;
                    save_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                S_LOAD: begin
                    if (tmr_q == HALF_LAST) begin
                        state_q <= S_SHIFT_HI;
                        load_q  <= 1'b0;
                        shift_q <= 1'b1;
                        tmr_q   <= {TMR_W{1'b0}};
                    end else begin
                        tmr_q   <= tmr_q + TMR_W'(1);
                    end
                end

                S_SHIFT_HI: begin
                    if (tmr_q == HALF_LAST) begin
                        state_q <= S_SHIFT_LO;
                        shift_q <= 1'b0;
                        tmr_q   <= {TMR_W{1'b0}};
                    end else begin
                        tmr_q   <= tmr_q + TMR_W'(1);
                    end
                end

                S_SHIFT_LO: begin
                    if (tmr_q == HALF_LAST) begin
                        tmr_q <= {TMR_W{1'b0}};
                        // pulse_q still holds the index of the pulse just finished
                        if (pulse_q == PULSE_LAST) begin
                            state_q <= S_SAVE;
                            save_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT_HI;
                            shift_q <= 1'b1;
                            pulse_q <= pulse_q + PLS_W'(1);
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_SAVE: begin
                    save_q  <= 1'b0;
                    done_q  <= 1'b0;
                    tmr_q   <= {TMR_W{1'b0}};
                    pulse_q <= {PLS_W{1'b0}};
                    if (bus.cont) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (!bus.cont) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        tmr_q   <= {TMR_W{1'b0}};
                    end else if (tmr_q == GAP_LAST) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        tmr_q   <= {TMR_W{1'b0}};
                        pulse_q <= {PLS_W{1'b0}};
                    end else begin
                        tmr_q   <= tmr_q + TMR_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tmr_q   <= {TMR_W{1'b0}};
                    pulse_q <= {PLS_W{1'b0}};
                    load_q  <= 1'b0;
                    shift_q <= 1'b0;
                    save_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next scan count: clear beats the SAVE-cycle increment; a manual
    // takeover during SAVE masks scan_done, so it also suppresses the count.
    always_comb begin
        scan_count_d = scan_count_q;
        if (bus.clear_cnt) begin
            scan_count_d = {CNT_W{1'b0}};
        end else if ((state_q == S_SAVE) && !bus.man_sel) begin
            scan_count_d = scan_count_q + CNT_W'(1);
        end else begin
            scan_count_d = scan_count_q;
        end
    end

    // Completed-scan counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            scan_count_q <= {CNT_W{1'b0}};
        end else begin
            scan_count_q <= scan_count_d;
        end
    end

    // Output arbitration: RPi pins pass straight through in manual mode.
    always_comb begin
        bus.shift_clk  = 1'b0;
        bus.load       = 1'b0;
        bus.save_data  = 1'b0;
        bus.busy       = 1'b0;
        bus.scan_done  = 1'b0;
        bus.scan_count = scan_count_q;
        if (bus.man_sel) begin
            bus.shift_clk = bus.shift_clk_pi;
            bus.load      = bus.load_pi;
            bus.save_data = bus.save_pi;
            bus.busy      = 1'b0;
            bus.scan_done = 1'b0;
        end else begin
            bus.shift_clk = shift_q;
            bus.load      = load_q;
            bus.save_data = save_q;
            bus.busy      = busy_q;
            bus.scan_done = done_q;
        end
    end

endmodule

// File: tb/tb_dff_scan_sequencer.sv
// tb_dff_scan_sequencer
// Randomised scoreboard bench. A reference model tracks the scan as an
// offset from the load rising edge and derives every output from the
// timing formulas; a separate monitor pops expected samples and compares.

module tb_dff_scan_sequencer;

    localparam int CL     = 4;
    localparam int HP     = 2;
    localparam int GP     = 6;
    localparam int CW     = 4;
    localparam int SAVE_P = HP * (2 * CL + 1);   // save offset from first load cycle

    typedef logic [CW+4:0] obs_t;  // {load, shift_clk, save_data, busy, scan_done, scan_count}

    logic CLK   = 1'b0;
    logic RST_B = 1'b0;

    dff_scan_sequencer_if #(.CNT_W(CW)) bus ();

    dff_scan_sequencer #(
        .CHAIN_LEN (CL),
        .HALF_PER  (HP),
        .GAP       (GP),
        .CNT_W     (CW)
    ) dut (
        .CLK   (CLK),
        .RST_B (RST_B),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_active;
    int   m_p;
    int   m_count;

    function automatic obs_t model_out();
        logic l, s, v, b, d;
        logic [CW-1:0] c;
        c = m_count[CW-1:0];
        if (bus.man_sel) begin
            l = bus.load_pi; s = bus.shift_clk_pi; v = bus.save_pi; b = 1'b0; d = 1'b0;
        end else if (m_active) begin
            l = (m_p < HP);
            s = (m_p >= HP) && (m_p < SAVE_P) && (((m_p - HP) % (2 * HP)) < HP);
            v = (m_p == SAVE_P);
            b = 1'b1;
            d = v;
        end else begin
            l = 1'b0; s = 1'b0; v = 1'b0; b = 1'b0; d = 1'b0;
        end
        return {l, s, v, b, d, c};
    endfunction

    // Reference model advances on every clock edge and queues the expected sample.
    always @(posedge CLK) begin
        if (!RST_B) begin
            m_active = 1'b0;
            m_p      = 0;
            m_count  = 0;
        end else begin
            if (bus.clear_cnt)
                m_count = 0;
            else if (m_active && m_p == SAVE_P && !bus.man_sel)
                m_count = (m_count + 1) % (1 << CW);

            if (bus.man_sel || bus.abort) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (bus.start || bus.cont) begin
                    m_active = 1'b1;
                    m_p      = 0;
                end
            end else if (m_p == SAVE_P) begin
                if (bus.cont) m_p = m_p + 1;
                else          m_active = 1'b0;
            end else if (m_p > SAVE_P) begin
                if (!bus.cont)             m_active = 1'b0;
                else if (m_p == SAVE_P + GP) m_p = 0;
                else                       m_p = m_p + 1;
            end else begin
                m_p = m_p + 1;
            end
        end
        exp_q.push_back(model_out());
    end

    // Monitor: compares the DUT outputs against the queued expectation.
    always @(posedge CLK) begin
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.load, bus.shift_clk, bus.save_data, bus.busy, bus.scan_done, bus.scan_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t {load,shift,save,busy,done,count} got=%b_%h want=%b_%h",
                         $time, a[CW+4:CW], a[CW-1:0], e[CW+4:CW], e[CW-1:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Returns at the negedge inside the n-th observed save cycle.
    task automatic wait_for_save(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n * 60 && seen < n; i++) begin
            @(negedge CLK);
            if (bus.save_data) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL wait_save timeout got=%0d want=%0d", seen, n);
        end
    endtask

    task automatic wait_for_shift();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge CLK);
            if (bus.shift_clk) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_shift timeout got=0 want=1");
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.cont = 1'b0; bus.abort = 1'b0; bus.clear_cnt = 1'b0;
        bus.man_sel = 1'b0; bus.shift_clk_pi = 1'b0; bus.load_pi = 1'b0; bus.save_pi = 1'b0;
        step(3);
        RST_B = 1'b1;
        step(2);

        // Single scan, plus a start while busy that must be ignored
        pulse_start();
        step(6);
        pulse_start();
        step(25);

        // Continuous mode, then drop cont during the gap
        bus.cont = 1'b1;
        wait_for_save(3);
        step(2);
        bus.cont = 1'b0;
        step(15);

        // Abort in mid-shift, then start+abort together, then a full scan
        pulse_start();
        wait_for_shift();
        step(3);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        step(3);
        bus.start = 1'b1; bus.abort = 1'b1;
        step(1);
        bus.start = 1'b0; bus.abort = 1'b0;
        step(3);
        pulse_start();
        step(25);

        // Manual pass-through with random pins; start/cont must be ignored
        bus.man_sel = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.shift_clk_pi = 1'($urandom_range(1));
            bus.load_pi      = 1'($urandom_range(1));
            bus.save_pi      = 1'($urandom_range(1));
            bus.start        = 1'($urandom_range(1));
            bus.cont         = 1'($urandom_range(1));
            step(1);
        end
        bus.man_sel = 1'b0; bus.start = 1'b0; bus.cont = 1'b0;
        bus.shift_clk_pi = 1'b0; bus.load_pi = 1'b0; bus.save_pi = 1'b0;
        step(3);

        // Manual takeover mid-scan acts as abort
        pulse_start();
        step(10);
        bus.man_sel = 1'b1;
        bus.shift_clk_pi = 1'b1;
        step(5);
        bus.man_sel = 1'b0; bus.shift_clk_pi = 1'b0;
        step(3);
        pulse_start();
        step(25);

        // Counter wrap over 17 scans, then clear in a SAVE cycle
        bus.cont = 1'b1;
        wait_for_save(17);
        step(1);
        wait_for_save(1);
        bus.clear_cnt = 1'b1;
        step(1);
        bus.clear_cnt = 1'b0;
        step(3);
        bus.cont = 1'b0;
        step(30);

        // Random traffic on every control
        for (int i = 0; i < 3000; i++) begin
            bus.start     = ($urandom_range(19) == 0);
            bus.abort     = ($urandom_range(149) == 0);
            bus.clear_cnt = ($urandom_range(199) == 0);
            if ($urandom_range(99) == 0)  bus.cont    = ~bus.cont;
            if ($urandom_range(299) == 0) bus.man_sel = ~bus.man_sel;
            bus.shift_clk_pi = 1'($urandom_range(1));
            bus.load_pi      = 1'($urandom_range(1));
            bus.save_pi      = 1'($urandom_range(1));
            step(1);
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.clear_cnt = 1'b0; bus.cont = 1'b0;
        bus.man_sel = 1'b0; bus.shift_clk_pi = 1'b0; bus.load_pi = 1'b0; bus.save_pi = 1'b0;
        step(30);

        // Bump the count, then async reset in SHIFT_HI
        pulse_start();
        step(25);
        pulse_start();
        wait_for_shift();
        #2;
        RST_B = 1'b0;
        #1;
        checks++;
        if ({bus.shift_clk, bus.busy, bus.scan_count} !== {1'b0, 1'b0, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset {shift,busy,count} got=%b_%b_%h want=0_0_0",
                     bus.shift_clk, bus.busy, bus.scan_count);
        end
        step(2);
        RST_B = 1'b1;
        step(3);
        pulse_start();
        step(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
